// File: rtl/cmd_exec_pkg.sv
// Shared types for the command executor: command/response packets, opcodes, status codes
// and FSM state encoding.
package cmd_exec_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10
  } cmd_op_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_BAD_OP  = 2'd1,
    ST_BUS_ERR = 2'd2,
    ST_TIMEOUT = 2'd3
  } rsp_status_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } exec_state_t;

  // op is kept raw so that illegal encodings can be echoed back unchanged
  typedef struct packed {
    logic [1:0]  op;
    logic [7:0]  addr;
    logic [31:0] data;
  } cmd_packet_t;

  typedef struct packed {
    rsp_status_t status;
    logic [1:0]  op;
    logic [7:0]  addr;
    logic [31:0] data;
  } rsp_packet_t;

  function automatic logic op_is_bus(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/cmd_exec_if.sv
// Bundle of the FIFO pop port, register bus and response port around cmd_exec.
// master = executor view, slave = environment view.
interface cmd_exec_if;
  import cmd_exec_pkg::*;

  logic        fifo_valid;
  cmd_packet_t fifo_rd_data;
  logic        fifo_rd_en;

  logic        reg_req;
  logic        reg_we;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_ack;
  logic        reg_err;
  logic [31:0] reg_rdata;

  logic        rsp_valid;
  logic        rsp_ready;
  rsp_packet_t rsp_data;

  logic        busy;

  modport master (
    input  fifo_valid, fifo_rd_data, reg_ack, reg_err, reg_rdata, rsp_ready,
    output fifo_rd_en, reg_req, reg_we, reg_addr, reg_wdata, rsp_valid, rsp_data, busy
  );

  modport slave (
    output fifo_valid, fifo_rd_data, reg_ack, reg_err, reg_rdata, rsp_ready,
    input  fifo_rd_en, reg_req, reg_we, reg_addr, reg_wdata, rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/cmd_exec.sv
// Command executor: pops one command, runs it on the register bus with a timeout,
// then holds one response until the consumer accepts it.
module cmd_exec
  import cmd_exec_pkg::*;
#(
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  cmd_exec_if.master    bus
);

  exec_state_t     state_q, state_d;
  cmd_packet_t     cmd_q, cmd_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            reg_req_q, reg_req_d;
  logic            reg_we_q, reg_we_d;
  logic            rsp_valid_q, rsp_valid_d;
  rsp_packet_t     rsp_data_q, rsp_data_d;
  logic            pop;
  logic            timeout;

  // The FIFO head is presented combinationally, so the pop strobe is too.
  assign pop     = (state_q == S_IDLE) && bus.fifo_valid && !rst;
  assign timeout = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      to_cnt_q    <= '0;
      reg_req_q   <= 1'b0;
      reg_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      to_cnt_q    <= to_cnt_d;
      reg_req_q   <= reg_req_d;
      reg_we_q    <= reg_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pop) state_d = op_is_bus(bus.fifo_rd_data.op) ? S_EXEC : S_RESP;
      S_EXEC:  if (bus.reg_ack || timeout) state_d = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_d       = cmd_q;
    to_cnt_d    = to_cnt_q;
    reg_req_d   = reg_req_q;
    reg_we_d    = reg_we_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          cmd_d    = bus.fifo_rd_data;
          to_cnt_d = '0;
          if (op_is_bus(bus.fifo_rd_data.op)) begin
            reg_req_d = 1'b1;
            reg_we_d  = (bus.fifo_rd_data.op == OP_WRITE);
          end else begin
            rsp_valid_d        = 1'b1;
            rsp_data_d.status  = ST_BAD_OP;
            rsp_data_d.op      = bus.fifo_rd_data.op;
            rsp_data_d.addr    = bus.fifo_rd_data.addr;
            rsp_data_d.data    = '0;
          end
        end
      end
      S_EXEC: begin
        rsp_data_d.op   = cmd_q.op;
        rsp_data_d.addr = cmd_q.addr;
        // An ack landing on the last allowed cycle beats the timeout.
        if (bus.reg_ack) begin
          reg_req_d         = 1'b0;
          rsp_valid_d       = 1'b1;
          rsp_data_d.status = bus.reg_err ? ST_BUS_ERR : ST_OK;
          rsp_data_d.data   = (!bus.reg_err && cmd_q.op == OP_READ) ? bus.reg_rdata : '0;
        end else if (timeout) begin
          reg_req_d         = 1'b0;
          rsp_valid_d       = 1'b1;
          rsp_data_d.status = ST_TIMEOUT;
          rsp_data_d.data   = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.fifo_rd_en = pop;
  assign bus.reg_req    = reg_req_q;
  assign bus.reg_we     = reg_we_q;
  assign bus.reg_addr   = cmd_q.addr;
  assign bus.reg_wdata  = cmd_q.data;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_cmd_exec.sv
// Bench for cmd_exec: a FIFO/bus/consumer environment process plus directed and random
// command sequences checked against an expected-response model.
module tb_cmd_exec;
  import cmd_exec_pkg::*;

  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmd_exec_if bus();

  cmd_exec #(.TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          d;      // ack on req cycle index d (0-based); d >= T means never
    bit          err;
    logic [31:0] rdata;
  } meta_t;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  len;
  } req_t;

  cmd_packet_t cmdq[$];
  meta_t       metaq[$];
  rsp_packet_t exp_rsp[$], got_rsp[$];
  req_t        exp_req[$], got_req[$];
  int          got_vlen[$], first_cyc[$], acc_cyc[$], pop_cyc[$];
  bit          got_stable[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int stall = 0;
  bit rand_ready = 0;
  bit stray = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Expected behaviour derived directly from the command and the bus reply plan.
  task automatic push_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [31:0] data,
                          input int d, input bit err, input logic [31:0] rdata,
                          input bit expect_rsp = 1);
    rsp_packet_t r;
    req_t        q;
    cmdq.push_back('{op, addr, data});
    metaq.push_back('{d, err, rdata});
    if (expect_rsp) begin
      r.op   = op;
      r.addr = addr;
      if (op != 2'b01 && op != 2'b10) begin
        r.status = ST_BAD_OP;
        r.data   = '0;
      end else begin
        q.we    = (op == 2'b10);
        q.addr  = addr;
        q.wdata = data;
        if (d < T) begin
          q.len    = 8'(d + 1);
          r.status = err ? ST_BUS_ERR : ST_OK;
          r.data   = (op == 2'b01 && !err) ? rdata : 32'h0;
        end else begin
          q.len    = 8'(T);
          r.status = ST_TIMEOUT;
          r.data   = '0;
        end
        exp_req.push_back(q);
      end
      exp_rsp.push_back(r);
    end
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int k = 0;
    while (got_rsp.size() < n && k < budget) begin
      tick();
      k++;
    end
    tick(2);
  endtask

  task automatic drain_check(input string tag);
    chk($sformatf("%s.nrsp", tag), 64'(got_rsp.size()), 64'(exp_rsp.size()));
    for (int i = 0; i < got_rsp.size() && i < exp_rsp.size(); i++) begin
      chk($sformatf("%s.rsp%0d", tag, i), 64'(got_rsp[i]), 64'(exp_rsp[i]));
      chk($sformatf("%s.stable%0d", tag, i), 64'(got_stable[i]), 64'(1));
    end
    chk($sformatf("%s.nreq", tag), 64'(got_req.size()), 64'(exp_req.size()));
    for (int i = 0; i < got_req.size() && i < exp_req.size(); i++)
      chk($sformatf("%s.req%0d", tag, i), 64'(got_req[i]), 64'(exp_req[i]));
    got_rsp.delete(); exp_rsp.delete(); got_req.delete(); exp_req.delete();
    got_vlen.delete(); got_stable.delete(); first_cyc.delete(); acc_cyc.delete();
    pop_cyc.delete();
  endtask

  // Environment: drives inputs on the falling edge, observes outputs just after.
  initial begin : env
    meta_t       cur;
    req_t        cur_req;
    rsp_packet_t first;
    int          req_run;
    int          vcnt;
    bit          stable;
    bit          pop_pend;
    cur = '{1000, 1'b0, 32'h0};
    cur_req = '0; first = '0;
    req_run = 0; vcnt = 0; stable = 1; pop_pend = 0;
    bus.fifo_valid = 0; bus.fifo_rd_data = '0;
    bus.reg_ack = 0; bus.reg_err = 0; bus.reg_rdata = '0; bus.rsp_ready = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pop_pend) begin
        cur = metaq.pop_front();
        void'(cmdq.pop_front());
        pop_pend = 0;
      end
      bus.fifo_valid = (cmdq.size() > 0);
      bus.fifo_rd_data = bus.fifo_valid ? cmdq[0] : cmd_packet_t'({$urandom, $urandom});
      if (bus.reg_req && req_run == cur.d) begin
        bus.reg_ack = 1; bus.reg_err = cur.err; bus.reg_rdata = cur.rdata;
      end else begin
        bus.reg_ack   = !bus.reg_req && stray && ($urandom_range(0, 5) == 0);
        bus.reg_err   = 1'($urandom);
        bus.reg_rdata = $urandom;
      end
      if (bus.rsp_valid && stall > 0) begin
        bus.rsp_ready = 0;
        stall--;
      end else begin
        bus.rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      #1;
      if (rst) begin
        req_run = 0; vcnt = 0; stable = 1; pop_pend = 0;
      end else begin
        if (bus.fifo_rd_en) begin
          pop_pend = 1;
          pop_cyc.push_back(cyc);
        end
        if (bus.reg_req) begin
          if (req_run == 0) cur_req = '{bus.reg_we, bus.reg_addr, bus.reg_wdata, 8'd0};
          req_run++;
        end else if (req_run > 0) begin
          cur_req.len = 8'(req_run);
          got_req.push_back(cur_req);
          req_run = 0;
        end
        if (bus.rsp_valid) begin
          if (vcnt == 0) begin
            first = bus.rsp_data;
            stable = 1;
            first_cyc.push_back(cyc);
          end else if (bus.rsp_data !== first) begin
            stable = 0;
          end
          vcnt++;
          if (bus.rsp_ready) begin
            got_rsp.push_back(first);
            got_vlen.push_back(vcnt);
            got_stable.push_back(stable);
            acc_cyc.push_back(cyc);
            vcnt = 0;
          end
        end
      end
    end
  end

  initial begin : seq
    int k;
    // Reset state
    rst = 1;
    tick(3);
    chk("rst.busy", 64'(bus.busy), 64'(0));
    chk("rst.reg_req", 64'(bus.reg_req), 64'(0));
    chk("rst.reg_we", 64'(bus.reg_we), 64'(0));
    chk("rst.reg_addr", 64'(bus.reg_addr), 64'(0));
    chk("rst.reg_wdata", 64'(bus.reg_wdata), 64'(0));
    chk("rst.rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst.rsp_data", 64'(bus.rsp_data), 64'(0));
    rst = 0;
    tick(2);

    // Write with ack two cycles into the request
    push_cmd(2'b10, 8'h10, 32'hDEADBEEF, 2, 0, 32'h0);
    wait_rsp(1, 50);
    chk("t1.pops", 64'(pop_cyc.size()), 64'(1));
    drain_check("t1");

    // Read held back by a stalled consumer; the second command must wait for accept
    stall = 5;
    push_cmd(2'b01, 8'h04, 32'h1234_5678, 1, 0, 32'hCAFEF00D);
    push_cmd(2'b10, 8'h20, 32'h0BAD_CAFE, 0, 0, 32'h0);
    wait_rsp(2, 100);
    chk("t2.vlen", 64'(got_vlen.size() > 0 ? got_vlen[0] : -1), 64'(6));
    chk("t2.pop_after_acc",
        64'(pop_cyc.size() > 1 && acc_cyc.size() > 0 ? pop_cyc[1] - acc_cyc[0] : -1), 64'(1));
    drain_check("t2");

    // Illegal opcodes: no bus access, response right after the pop
    push_cmd(2'b11, 8'h33, 32'hFFFF_FFFF, 0, 0, 32'h0);
    push_cmd(2'b00, 8'h34, 32'h5555_AAAA, 0, 0, 32'h0);
    wait_rsp(2, 50);
    chk("t3.rsp_lat",
        64'(first_cyc.size() > 0 && pop_cyc.size() > 0 ? first_cyc[0] - pop_cyc[0] : -1), 64'(1));
    drain_check("t3");

    // Timeout, and acks on the final allowed cycle (ack wins)
    push_cmd(2'b10, 8'h40, 32'h0000_0040, 1000, 0, 32'h0);
    push_cmd(2'b01, 8'h41, 32'h0, T - 1, 1, 32'h7777_7777);
    push_cmd(2'b01, 8'h42, 32'h0, T - 1, 0, 32'h1357_9BDF);
    push_cmd(2'b01, 8'h43, 32'h0, 1000, 0, 32'h0);
    wait_rsp(4, 200);
    drain_check("t4");

    // Back-to-back commands at the minimum period
    push_cmd(2'b10, 8'h01, 32'h1111_1111, 0, 0, 32'h0);
    push_cmd(2'b01, 8'h02, 32'h0, 0, 0, 32'h2222_2222);
    push_cmd(2'b01, 8'h03, 32'h0, 0, 1, 32'h3333_3333);
    wait_rsp(3, 50);
    chk("t5.gap01", 64'(pop_cyc.size() > 2 ? pop_cyc[1] - pop_cyc[0] : -1), 64'(3));
    chk("t5.gap12", 64'(pop_cyc.size() > 2 ? pop_cyc[2] - pop_cyc[1] : -1), 64'(3));
    drain_check("t5");

    // Reset in the middle of a bus request discards the command
    push_cmd(2'b10, 8'h50, 32'h5050_5050, 1000, 0, 32'h0, 0);
    k = 0;
    while (!bus.reg_req && k < 20) begin tick(); k++; end
    chk("t6.req_seen", 64'(bus.reg_req), 64'(1));
    push_cmd(2'b01, 8'h51, 32'h0, 1, 0, 32'h5151_5151);
    tick(2);
    rst = 1;
    tick();
    chk("t6.reg_req", 64'(bus.reg_req), 64'(0));
    chk("t6.busy", 64'(bus.busy), 64'(0));
    chk("t6.rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("t6.rsp_data", 64'(bus.rsp_data), 64'(0));
    rst = 0;
    wait_rsp(1, 50);
    chk("t6.pops", 64'(pop_cyc.size()), 64'(2));
    drain_check("t6");

    // Random commands, bus latencies, errors, consumer stalls and stray acks
    rand_ready = 1;
    stray = 1;
    for (int i = 0; i < 60; i++)
      push_cmd(2'($urandom_range(0, 3)), 8'($urandom), $urandom,
               $urandom_range(0, T + 2), 1'($urandom), $urandom);
    wait_rsp(60, 6000);
    drain_check("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
